issue_stage: RTL and testbench

- Register-read/issue buffer that sits between dispatch and the execute stage, and is the producer side of the execute-stage issue handshake.
- Holds up to IQ_DEPTH renamed instructions and captures source operands through wakeup snooping of the execute forwarding bus.
- Each cycle it selects the oldest entry whose operands are ready and whose functional unit reports ready, and presents it on the RR_valid/EXE_in_* interface.
- Squashes entries younger than a mispredicting branch.

---
 rtl/issue_stage_pkg.sv | 75 +++++++
 rtl/issue_stage_age_select.sv | 29 ++
 rtl/issue_stage.sv | 189 ++++++++++++++++++
 tb/tb_issue_stage.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_stage_pkg.sv
// Shared issue-stage types: entry layout, functional-unit codes, ROB age and wakeup helpers.
// `ROB_LEN sets the ROB size and defaults to 8 when the build does not supply it.
`ifndef ROB_LEN
`define ROB_LEN 8
`endif

package issue_stage_pkg;

  localparam int ROB_LEN   = `ROB_LEN;
  localparam int ROB_IDX_W = $clog2(ROB_LEN);

  typedef logic [ROB_IDX_W-1:0] rob_idx_t;

  typedef enum logic [2:0] {
    FU_ALU = 3'd0,
    FU_MUL = 3'd1,
    FU_DIV = 3'd2,
    FU_BRU = 3'd3,
    FU_CSR = 3'd4,
    FU_AMO = 3'd5,
    FU_LD  = 3'd6,
    FU_ST  = 3'd7
  } fu_sel_e;

  typedef struct packed {
    fu_sel_e     fu_sel;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [6:0]  rd;
    logic [4:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    rob_idx_t    rob_idx;
    logic        jump;
  } payload_t;

  typedef struct packed {
    logic        rdy;
    rob_idx_t    tag;
    logic [31:0] data;
  } operand_t;

  typedef struct packed {
    logic     valid;
    payload_t pl;
    operand_t rs1;
    operand_t rs2;
  } entry_t;

  // Distance from the ROB head; smaller means older.
  function automatic rob_idx_t rob_age(rob_idx_t idx, rob_idx_t head);
    if (idx >= head) return idx - head;
    return rob_idx_t'(ROB_LEN + int'(idx) - int'(head));
  endfunction

  function automatic operand_t wake(operand_t opnd, logic bus_valid, rob_idx_t bus_idx,
                                    logic [31:0] bus_data);
    operand_t res;
    res = opnd;
    if (!opnd.rdy && bus_valid && (opnd.tag == bus_idx)) begin
      res.rdy  = 1'b1;
      res.data = bus_data;
    end
    return res;
  endfunction

  // EX is applied first so it wins when both buses carry the same tag.
  function automatic operand_t snoop(operand_t opnd,
                                     logic ex_valid, rob_idx_t ex_idx, logic [31:0] ex_data,
                                     logic wb_valid, rob_idx_t wb_idx, logic [31:0] wb_data);
    return wake(wake(opnd, ex_valid, ex_idx, ex_data), wb_valid, wb_idx, wb_data);
  endfunction

endpackage

// File: rtl/issue_stage_age_select.sv
// Combinational oldest-eligible picker: one-hot grant plus its binary index.
module iq_age_select #(
  parameter  int N     = 8,
  parameter  int AGE_W = 3,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]            eligible,
  input  logic [N-1:0][AGE_W-1:0] age,
  output logic [N-1:0]            grant,
  output logic [IDX_W-1:0]        grant_idx,
  output logic                    any_grant
);

  // NOTE: every output of this always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = eligible[i];
      for (int j = 0; j < N; j++) begin
        if ((j != i) && eligible[j] && (age[j] < age[i])) grant[i] = 1'b0;
      end
      if (grant[i]) grant_idx = IDX_W'(i);
    end
  end

  assign any_grant = |eligible;

endmodule

// File: rtl/issue_stage.sv
// Register-read/issue buffer: wakeup snooping, oldest-ready issue and mispredict squash.
// Define IQ_WB_WAKEUP_EN to add the WB_out_* second wakeup port.
module issue_stage
  import issue_stage_pkg::*;
#(
  parameter int IQ_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dp_valid,
  output logic                 dp_ready,
  input  logic [2:0]           dp_fu_sel,
  input  logic [31:0]          dp_inst,
  input  logic [31:0]          dp_pc,
  input  logic [31:0]          dp_imm,
  input  logic [6:0]           dp_rd,
  input  logic [4:0]           dp_op,
  input  logic [2:0]           dp_f3,
  input  logic [6:0]           dp_f7,
  input  logic                 dp_jump,
  input  logic [ROB_IDX_W-1:0] dp_rob_idx,
  input  logic                 dp_rs1_rdy,
  input  logic                 dp_rs2_rdy,
  input  logic [ROB_IDX_W-1:0] dp_rs1_tag,
  input  logic [ROB_IDX_W-1:0] dp_rs2_tag,
  input  logic [31:0]          dp_rs1_data,
  input  logic [31:0]          dp_rs2_data,
  input  logic [ROB_IDX_W-1:0] rob_head,
  input  logic                 EX_out_valid,
  input  logic [ROB_IDX_W-1:0] EX_out_rob_idx,
  input  logic [31:0]          EX_out_data,
`ifdef IQ_WB_WAKEUP_EN
  input  logic                 WB_out_valid,
  input  logic [ROB_IDX_W-1:0] WB_out_rob_idx,
  input  logic [31:0]          WB_out_data,
`endif
  input  logic [7:0]           EX_ready,
  input  logic                 mispredict,
  input  logic [ROB_IDX_W-1:0] mis_rob_idx,
  output logic                 RR_valid,
  output logic [2:0]           EXE_in_fu_sel,
  output logic [31:0]          EXE_in_inst,
  output logic [31:0]          EXE_in_pc,
  output logic [31:0]          EXE_in_imm,
  output logic [6:0]           EXE_in_rd,
  output logic [4:0]           EXE_in_op,
  output logic [2:0]           EXE_in_f3,
  output logic [6:0]           EXE_in_f7,
  output logic [ROB_IDX_W-1:0] EXE_in_rob_idx,
  output logic                 EXE_in_jump,
  output logic [31:0]          EXE_in_rs1_data,
  output logic [31:0]          EXE_in_rs2_data
);

  localparam int IDX_W = $clog2(IQ_DEPTH);

  entry_t entries_q [IQ_DEPTH];
  entry_t entries_d [IQ_DEPTH];
  entry_t new_entry;

  logic [IQ_DEPTH-1:0]                free_vec;
  logic [IQ_DEPTH-1:0]                alloc_oh;
  logic [IQ_DEPTH-1:0]                eligible;
  logic [IQ_DEPTH-1:0]                grant;
  logic [IQ_DEPTH-1:0][ROB_IDX_W-1:0] ages;
  logic [IDX_W-1:0]                   grant_idx;
  logic                               issue_any;
  rob_idx_t                           mis_age;

  payload_t    sel_pl;
  logic [31:0] sel_rs1;
  logic [31:0] sel_rs2;

  logic        wb_valid;
  rob_idx_t    wb_rob_idx;
  logic [31:0] wb_data;

`ifdef IQ_WB_WAKEUP_EN
  assign wb_valid   = WB_out_valid;
  assign wb_rob_idx = WB_out_rob_idx;
  assign wb_data    = WB_out_data;
`else
  assign wb_valid   = 1'b0;
  assign wb_rob_idx = '0;
  assign wb_data    = '0;
`endif

  always_comb begin
    for (int i = 0; i < IQ_DEPTH; i++) begin
      free_vec[i] = !entries_q[i].valid;
      ages[i]     = rob_age(entries_q[i].pl.rob_idx, rob_head);
      eligible[i] = entries_q[i].valid && entries_q[i].rs1.rdy && entries_q[i].rs2.rdy &&
                    EX_ready[entries_q[i].pl.fu_sel];
    end
  end

  // Lowest free slot, taken from registered state only.
  assign alloc_oh = free_vec & (~free_vec + IQ_DEPTH'(1));
  assign dp_ready = |free_vec;

  iq_age_select #(
    .N     (IQ_DEPTH),
    .AGE_W (ROB_IDX_W)
  ) u_age_select (
    .eligible  (eligible),
    .age       (ages),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (issue_any)
  );

  always_comb begin
    new_entry            = '0;
    new_entry.valid      = 1'b1;
    new_entry.pl.fu_sel  = fu_sel_e'(dp_fu_sel);
    new_entry.pl.inst    = dp_inst;
    new_entry.pl.pc      = dp_pc;
    new_entry.pl.imm     = dp_imm;
    new_entry.pl.rd      = dp_rd;
    new_entry.pl.op      = dp_op;
    new_entry.pl.f3      = dp_f3;
    new_entry.pl.f7      = dp_f7;
    new_entry.pl.rob_idx = dp_rob_idx;
    new_entry.pl.jump    = dp_jump;
    new_entry.rs1 = snoop(operand_t'({dp_rs1_rdy, dp_rs1_tag, dp_rs1_data}),
                          EX_out_valid, EX_out_rob_idx, EX_out_data,
                          wb_valid, wb_rob_idx, wb_data);
    new_entry.rs2 = snoop(operand_t'({dp_rs2_rdy, dp_rs2_tag, dp_rs2_data}),
                          EX_out_valid, EX_out_rob_idx, EX_out_data,
                          wb_valid, wb_rob_idx, wb_data);
  end

  // NOTE: blocking assignments in this always_comb apply issue, then allocate, then flush in
  // order, so each later step sees the result of the earlier ones within the same cycle.
  always_comb begin
    mis_age = rob_age(mis_rob_idx, rob_head);
    for (int i = 0; i < IQ_DEPTH; i++) begin
      entries_d[i] = entries_q[i];
      if (entries_q[i].valid) begin
        entries_d[i].rs1 = snoop(entries_q[i].rs1, EX_out_valid, EX_out_rob_idx, EX_out_data,
                                 wb_valid, wb_rob_idx, wb_data);
        entries_d[i].rs2 = snoop(entries_q[i].rs2, EX_out_valid, EX_out_rob_idx, EX_out_data,
                                 wb_valid, wb_rob_idx, wb_data);
      end
      if (grant[i]) entries_d[i].valid = 1'b0;
      if (dp_valid && alloc_oh[i]) entries_d[i] = new_entry;
      if (mispredict && entries_d[i].valid &&
          (rob_age(entries_d[i].pl.rob_idx, rob_head) > mis_age)) begin
        entries_d[i].valid = 1'b0;
      end
    end
  end

  // NOTE: the whole entry array is reset, not just the valid bits: it is small and drives the
  // issue mux directly, so no unknown payload can ever reach EXE_in_*.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < IQ_DEPTH; i++) entries_q[i] <= '0;
    end else begin
      for (int i = 0; i < IQ_DEPTH; i++) entries_q[i] <= entries_d[i];
    end
  end

  always_comb begin
    sel_pl  = entries_q[grant_idx].pl;
    sel_rs1 = entries_q[grant_idx].rs1.data;
    sel_rs2 = entries_q[grant_idx].rs2.data;
    if (!issue_any) begin
      sel_pl  = '0;
      sel_rs1 = '0;
      sel_rs2 = '0;
    end
  end

  assign RR_valid        = issue_any;
  assign EXE_in_fu_sel   = sel_pl.fu_sel;
  assign EXE_in_inst     = sel_pl.inst;
  assign EXE_in_pc       = sel_pl.pc;
  assign EXE_in_imm      = sel_pl.imm;
  assign EXE_in_rd       = sel_pl.rd;
  assign EXE_in_op       = sel_pl.op;
  assign EXE_in_f3       = sel_pl.f3;
  assign EXE_in_f7       = sel_pl.f7;
  assign EXE_in_rob_idx  = sel_pl.rob_idx;
  assign EXE_in_jump     = sel_pl.jump;
  assign EXE_in_rs1_data = sel_rs1;
  assign EXE_in_rs2_data = sel_rs2;

endmodule

// File: tb/tb_issue_stage.sv
// Directed bench for issue_stage with an in-order scoreboard of expected issues.
module tb_issue_stage;
  import issue_stage_pkg::*;

  logic        clk, rst;
  logic        dp_valid, dp_ready;
  logic [2:0]  dp_fu_sel;
  logic [31:0] dp_inst, dp_pc, dp_imm;
  logic [6:0]  dp_rd;
  logic [4:0]  dp_op;
  logic [2:0]  dp_f3;
  logic [6:0]  dp_f7;
  logic        dp_jump;
  rob_idx_t    dp_rob_idx, dp_rs1_tag, dp_rs2_tag;
  logic        dp_rs1_rdy, dp_rs2_rdy;
  logic [31:0] dp_rs1_data, dp_rs2_data;
  rob_idx_t    rob_head;
  logic        EX_out_valid;
  rob_idx_t    EX_out_rob_idx;
  logic [31:0] EX_out_data;
`ifdef IQ_WB_WAKEUP_EN
  logic        WB_out_valid;
  rob_idx_t    WB_out_rob_idx;
  logic [31:0] WB_out_data;
`endif
  logic [7:0]  EX_ready;
  logic        mispredict;
  rob_idx_t    mis_rob_idx;
  logic        RR_valid;
  logic [2:0]  EXE_in_fu_sel;
  logic [31:0] EXE_in_inst, EXE_in_pc, EXE_in_imm;
  logic [6:0]  EXE_in_rd;
  logic [4:0]  EXE_in_op;
  logic [2:0]  EXE_in_f3;
  logic [6:0]  EXE_in_f7;
  rob_idx_t    EXE_in_rob_idx;
  logic        EXE_in_jump;
  logic [31:0] EXE_in_rs1_data, EXE_in_rs2_data;

  issue_stage #(.IQ_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .dp_valid(dp_valid), .dp_ready(dp_ready),
    .dp_fu_sel(dp_fu_sel), .dp_inst(dp_inst), .dp_pc(dp_pc), .dp_imm(dp_imm), .dp_rd(dp_rd),
    .dp_op(dp_op), .dp_f3(dp_f3), .dp_f7(dp_f7), .dp_jump(dp_jump), .dp_rob_idx(dp_rob_idx),
    .dp_rs1_rdy(dp_rs1_rdy), .dp_rs2_rdy(dp_rs2_rdy), .dp_rs1_tag(dp_rs1_tag),
    .dp_rs2_tag(dp_rs2_tag), .dp_rs1_data(dp_rs1_data), .dp_rs2_data(dp_rs2_data),
    .rob_head(rob_head), .EX_out_valid(EX_out_valid), .EX_out_rob_idx(EX_out_rob_idx),
    .EX_out_data(EX_out_data),
`ifdef IQ_WB_WAKEUP_EN
    .WB_out_valid(WB_out_valid), .WB_out_rob_idx(WB_out_rob_idx), .WB_out_data(WB_out_data),
`endif
    .EX_ready(EX_ready), .mispredict(mispredict), .mis_rob_idx(mis_rob_idx),
    .RR_valid(RR_valid), .EXE_in_fu_sel(EXE_in_fu_sel), .EXE_in_inst(EXE_in_inst),
    .EXE_in_pc(EXE_in_pc), .EXE_in_imm(EXE_in_imm), .EXE_in_rd(EXE_in_rd),
    .EXE_in_op(EXE_in_op), .EXE_in_f3(EXE_in_f3), .EXE_in_f7(EXE_in_f7),
    .EXE_in_rob_idx(EXE_in_rob_idx), .EXE_in_jump(EXE_in_jump),
    .EXE_in_rs1_data(EXE_in_rs1_data), .EXE_in_rs2_data(EXE_in_rs2_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  typedef struct {
    rob_idx_t    rob;
    logic [2:0]  fu;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } exp_t;

  exp_t sb[$];

  function automatic logic [31:0] pc_of(rob_idx_t r);
    return 32'h0000_1000 + (32'(r) << 2);
  endfunction

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic dispatch(rob_idx_t rob, logic [2:0] fu,
                          logic r1_rdy, rob_idx_t r1_tag, logic [31:0] r1_d,
                          logic r2_rdy, rob_idx_t r2_tag, logic [31:0] r2_d);
    dp_valid    = 1'b1;
    dp_rob_idx  = rob;
    dp_fu_sel   = fu;
    dp_pc       = pc_of(rob);
    dp_inst     = 32'h0000_0013 | (32'(rob) << 7);
    dp_imm      = 32'(rob) * 3;
    dp_rd       = 7'(rob) + 7'd1;
    dp_op       = 5'd3;
    dp_f3       = 3'd2;
    dp_f7       = 7'd0;
    dp_jump     = 1'b0;
    dp_rs1_rdy  = r1_rdy;
    dp_rs1_tag  = r1_tag;
    dp_rs1_data = r1_d;
    dp_rs2_rdy  = r2_rdy;
    dp_rs2_tag  = r2_tag;
    dp_rs2_data = r2_d;
  endtask

  task automatic expect_issue(rob_idx_t rob, logic [2:0] fu, logic [31:0] r1, logic [31:0] r2);
    exp_t e;
    e.rob = rob;
    e.fu  = fu;
    e.pc  = pc_of(rob);
    e.rs1 = r1;
    e.rs2 = r2;
    sb.push_back(e);
  endtask

  task automatic pulse_ex(rob_idx_t rob, logic [31:0] data);
    EX_out_valid   = 1'b1;
    EX_out_rob_idx = rob;
    EX_out_data    = data;
  endtask

  task automatic settle();
    #2;
  endtask

  // Score this cycle's issue, then advance to just after the next rising edge.
  task automatic next();
    exp_t e;
    #2;
    if (RR_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_issue", 128'(RR_valid), 128'(0));
      end else begin
        e = sb.pop_front();
        check("sb_issue",
              128'({EXE_in_rob_idx, EXE_in_fu_sel, EXE_in_pc, EXE_in_rs1_data, EXE_in_rs2_data}),
              128'({e.rob, e.fu, e.pc, e.rs1, e.rs2}));
      end
    end
    @(posedge clk);
    #1;
    dp_valid     = 1'b0;
    EX_out_valid = 1'b0;
    mispredict   = 1'b0;
  endtask

  task automatic rr_is(string tag, logic v, rob_idx_t rob);
    check({tag, "_valid"}, 128'(RR_valid), 128'(v));
    if (v) check({tag, "_rob"}, 128'(EXE_in_rob_idx), 128'(rob));
    else   check({tag, "_zero"}, 128'({EXE_in_pc, EXE_in_rs1_data}), 128'(0));
  endtask

  initial begin
    rst = 1'b0;
    dp_valid = 1'b0; dp_fu_sel = '0; dp_inst = '0; dp_pc = '0; dp_imm = '0; dp_rd = '0;
    dp_op = '0; dp_f3 = '0; dp_f7 = '0; dp_jump = 1'b0; dp_rob_idx = '0;
    dp_rs1_rdy = 1'b0; dp_rs2_rdy = 1'b0; dp_rs1_tag = '0; dp_rs2_tag = '0;
    dp_rs1_data = '0; dp_rs2_data = '0;
    rob_head = '0; EX_out_valid = 1'b0; EX_out_rob_idx = '0; EX_out_data = '0;
`ifdef IQ_WB_WAKEUP_EN
    WB_out_valid = 1'b0; WB_out_rob_idx = '0; WB_out_data = '0;
`endif
    EX_ready = 8'hFF; mispredict = 1'b0; mis_rob_idx = '0;

    repeat (2) @(posedge clk);
    #1;
    settle();
    check("reset_dp_ready", 128'(dp_ready), 128'(1));
    rr_is("reset", 1'b0, '0);
    check("reset_exe_rob", 128'(EXE_in_rob_idx), 128'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic dispatch to issue, one-cycle latency.
    dispatch(2, FU_ALU, 1'b1, 0, 32'd5, 1'b1, 0, 32'd7);
    expect_issue(2, FU_ALU, 32'd5, 32'd7);
    settle(); rr_is("t1_fresh", 1'b0, '0);
    next();
    settle(); rr_is("t1_issue", 1'b1, 2); check("t1_rs1", 128'(EXE_in_rs1_data), 128'(5));
    next();
    settle(); rr_is("t1_after", 1'b0, '0);
    next();

    // Wakeup of a held entry from the forwarding bus.
    dispatch(3, FU_ALU, 1'b0, 1, 32'hDEAD, 1'b1, 0, 32'd9);
    next();
    settle(); rr_is("t2_wait", 1'b0, '0);
    next();
    pulse_ex(1, 32'hABCD);
    expect_issue(3, FU_ALU, 32'hABCD, 32'd9);
    settle(); rr_is("t2_pulse", 1'b0, '0);
    next();
    settle(); rr_is("t2_issue", 1'b1, 3); check("t2_rs1", 128'(EXE_in_rs1_data), 128'(32'hABCD));
    next();

    // Same-cycle wakeup on dispatch, dual wakeup, and ready data kept.
    dispatch(5, FU_ALU, 1'b1, 0, 32'h11, 1'b0, 0, 32'h0);
    pulse_ex(0, 32'h55);
    expect_issue(5, FU_ALU, 32'h11, 32'h55);
    next();
    settle(); rr_is("t3_disp_wake", 1'b1, 5); check("t3_rs2", 128'(EXE_in_rs2_data), 128'(32'h55));
    next();
    dispatch(6, FU_BRU, 1'b0, 2, 32'h0, 1'b0, 2, 32'h0);
    next();
    pulse_ex(2, 32'h77);
    expect_issue(6, FU_BRU, 32'h77, 32'h77);
    settle(); rr_is("t3_dual_pulse", 1'b0, '0);
    next();
    settle(); rr_is("t3_dual", 1'b1, 6);
    next();
    dispatch(7, FU_ALU, 1'b1, 4, 32'h31, 1'b0, 4, 32'h0);
    next();
    pulse_ex(4, 32'h99);
    expect_issue(7, FU_ALU, 32'h31, 32'h99);
    next();
    settle(); rr_is("t3_keep", 1'b1, 7); check("t3_keep_rs1", 128'(EXE_in_rs1_data), 128'(32'h31));
    next();

    // Age order relative to rob_head with wraparound.
    rob_head = 6;
    EX_ready = 8'h00;
    dispatch(1, FU_ALU, 1'b1, 0, 32'h101, 1'b1, 0, 32'h102);
    next();
    dispatch(7, FU_ALU, 1'b1, 0, 32'h701, 1'b1, 0, 32'h702);
    next();
    settle(); rr_is("t4_blocked", 1'b0, '0);
    EX_ready = 8'hFF;
    expect_issue(7, FU_ALU, 32'h701, 32'h702);
    expect_issue(1, FU_ALU, 32'h101, 32'h102);
    settle(); rr_is("t4_first", 1'b1, 7);
    next();
    settle(); rr_is("t4_second", 1'b1, 1);
    next();
    settle(); rr_is("t4_empty", 1'b0, '0);
    next();
    rob_head = 0;

    // Functional unit back-pressure.
    EX_ready = 8'hFD;
    dispatch(4, FU_MUL, 1'b1, 0, 32'h44, 1'b1, 0, 32'h45);
    next();
    repeat (4) begin
      settle(); rr_is("t5_stall", 1'b0, '0);
      next();
    end
    EX_ready = 8'hFF;
    expect_issue(4, FU_MUL, 32'h44, 32'h45);
    settle(); rr_is("t5_go", 1'b1, 4);
    next();

    // Fill all entries; dp_ready only returns the cycle after a slot is freed.
    EX_ready = 8'h00;
    for (int i = 0; i < 8; i++) begin
      settle(); check("t6_ready_before", 128'(dp_ready), 128'(1));
      dispatch(rob_idx_t'(i), FU_ALU, 1'b1, 0, 32'h600 + i, 1'b1, 0, 32'h700 + i);
      next();
    end
    settle(); check("t6_full", 128'(dp_ready), 128'(0));
    dispatch(3, FU_ALU, 1'b1, 0, 32'hBAD, 1'b1, 0, 32'hBAD);
    dp_pc = 32'hDEAD_BEEF;
    next();
    settle(); check("t6_still_full", 128'(dp_ready), 128'(0));
    for (int i = 0; i < 8; i++) expect_issue(rob_idx_t'(i), FU_ALU, 32'h600 + i, 32'h700 + i);
    EX_ready = 8'hFF;
    settle(); rr_is("t6_drain0", 1'b1, 0); check("t6_full_at_issue", 128'(dp_ready), 128'(0));
    next();
    settle(); rr_is("t6_drain1", 1'b1, 1); check("t6_ready_after_issue", 128'(dp_ready), 128'(1));
    next();
    repeat (6) next();
    settle(); rr_is("t6_drained", 1'b0, '0);
    next();

    // Mispredict flush of younger entries and of a same-cycle dispatch.
    rob_head = 0;
    EX_ready = 8'h00;
    dispatch(2, FU_ALU, 1'b1, 0, 32'h201, 1'b1, 0, 32'h202);
    next();
    dispatch(4, FU_ALU, 1'b1, 0, 32'h401, 1'b1, 0, 32'h402);
    next();
    dispatch(5, FU_ALU, 1'b1, 0, 32'h501, 1'b1, 0, 32'h502);
    next();
    mispredict  = 1'b1;
    mis_rob_idx = 3;
    dispatch(6, FU_ALU, 1'b1, 0, 32'h601, 1'b1, 0, 32'h602);
    next();
    settle(); rr_is("t7_blocked", 1'b0, '0);
    EX_ready = 8'hFF;
    expect_issue(2, FU_ALU, 32'h201, 32'h202);
    settle(); rr_is("t7_survivor", 1'b1, 2);
    next();
    settle(); rr_is("t7_flushed", 1'b0, '0);
    next();
    repeat (3) next();
    settle(); rr_is("t7_quiet", 1'b0, '0);
    next();

    check("sb_empty", 128'(sb.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
